// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - right-to-left square-and-multiply modexp sequencer
// Drives a shared WxW multiplier and 2W divider through run/ready_n handshakes.
module modexp_ctrl #(
  parameter int W       = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   base,
  input  logic [W-1:0]   exp,
  input  logic [W-1:0]   modulus,
  output logic [W-1:0]   result,
  output logic           ready_n,
  output logic           busy,
  output logic           err,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  output logic           mul_rst_n,
  input  logic [2*W-1:0] mul_result,
  input  logic           mul_ready_n,
  output logic [2*W-1:0] div_a,
  output logic [2*W-1:0] div_b,
  output logic           div_rst_n,
  input  logic [2*W-1:0] div_r,
  input  logic           div_ready_n
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_RED, S_STEP, S_MULR, S_DIVR, S_MULB, S_DIVB, S_DONE
  } state_t;

  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [W-1:0]   ONE     = {{(W-1){1'b0}}, 1'b1};

  state_t         state_q;
  logic [W-1:0]   r_q, b_q, e_q, n_q;
  logic [WDW-1:0] wdog_q;
  logic           run_q;

  logic           is_mul, unit_done, unused_div_hi;
  logic [W-1:0]   e_half;

  assign is_mul        = (state_q == S_MULR) || (state_q == S_MULB);
  assign unit_done     = is_mul ? !mul_ready_n : !div_ready_n;
  assign e_half        = e_q >> 1;
  // Remainder is always below n, so the upper half of div_r carries nothing.
  assign unused_div_hi = ^div_r[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      b_q       <= '0;
      e_q       <= '0;
      n_q       <= '0;
      wdog_q    <= '0;
      run_q     <= 1'b0;
      result    <= '0;
      ready_n   <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_rst_n <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      div_rst_n <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            b_q     <= base;
            e_q     <= exp;
            n_q     <= modulus;
            r_q     <= ONE;
            run_q   <= 1'b0;
            result  <= '0;
            ready_n <= 1'b1;
            err     <= 1'b0;
            busy    <= 1'b1;
            div_b   <= {{W{1'b0}}, modulus};
            state_q <= S_CHK;
          end
        end
        S_CHK: begin
          if (n_q == '0 || n_q == ONE) begin
            err     <= (n_q == '0);
            result  <= '0;
            ready_n <= 1'b0;
            busy    <= 1'b0;
            state_q <= S_DONE;
          end else begin
            div_a   <= {{W{1'b0}}, b_q};
            state_q <= S_RED;
          end
        end
        S_STEP: begin
          if (e_q == '0) begin
            result  <= r_q;
            ready_n <= 1'b0;
            busy    <= 1'b0;
            state_q <= S_DONE;
          end else if (e_q[0]) begin
            mul_a   <= r_q;
            mul_b   <= b_q;
            state_q <= S_MULR;
          end else begin
            // Even exponent: a nonzero shifted value is guaranteed, so square next.
            e_q     <= e_half;
            mul_a   <= b_q;
            mul_b   <= b_q;
            state_q <= S_MULB;
          end
        end
        default: begin
          if (!run_q) begin
            run_q  <= 1'b1;
            wdog_q <= '0;
            if (is_mul) mul_rst_n <= 1'b1;
            else        div_rst_n <= 1'b1;
          end else if (unit_done) begin
            run_q     <= 1'b0;
            mul_rst_n <= 1'b0;
            div_rst_n <= 1'b0;
            case (state_q)
              S_RED: begin
                b_q     <= div_r[W-1:0];
                state_q <= S_STEP;
              end
              S_MULR: begin
                div_a   <= mul_result;
                state_q <= S_DIVR;
              end
              S_DIVR: begin
                r_q <= div_r[W-1:0];
                e_q <= e_half;
                if (e_half != '0) begin
                  mul_a   <= b_q;
                  mul_b   <= b_q;
                  state_q <= S_MULB;
                end else begin
                  state_q <= S_STEP;
                end
              end
              S_MULB: begin
                div_a   <= mul_result;
                state_q <= S_DIVB;
              end
              S_DIVB: begin
                b_q     <= div_r[W-1:0];
                state_q <= S_STEP;
              end
              default: state_q <= S_IDLE;
            endcase
          end else if (wdog_q == WD_LAST) begin
            run_q     <= 1'b0;
            mul_rst_n <= 1'b0;
            div_rst_n <= 1'b0;
            err       <= 1'b1;
            result    <= '0;
            ready_n   <= 1'b0;
            busy      <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - randomized self-checking bench for modexp_ctrl
// Variable-latency multiplier/divider models, protocol monitor, modpow reference.
module tb_modexp_ctrl;

  localparam int W  = 32;
  localparam int TO = 100;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    base = '0, exp = '0, modulus = '0;
  logic [W-1:0]    result;
  logic            ready_n, busy, err;
  logic [W-1:0]    mul_a, mul_b;
  logic            mul_rst_n;
  logic [2*W-1:0]  mul_result = '0;
  logic            mul_ready_n = 1'b1;
  logic [2*W-1:0]  div_a, div_b;
  logic            div_rst_n;
  logic [2*W-1:0]  div_r = '0;
  logic            div_ready_n = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int mul_iss = 0, div_iss = 0, prot_err = 0, cyc = 0;
  int mul_lat = 0, div_lat = 0;
  bit mul_hang = 1'b0;

  modexp_ctrl #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(exp), .modulus(modulus),
    .result(result), .ready_n(ready_n), .busy(busy), .err(err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rst_n(mul_rst_n), .mul_result(mul_result),
    .mul_ready_n(mul_ready_n), .div_a(div_a), .div_b(div_b), .div_rst_n(div_rst_n),
    .div_r(div_r), .div_ready_n(div_ready_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge mul_rst_n) mul_iss++;
  always @(posedge div_rst_n) div_iss++;

  always @(posedge clk) begin
    if (!mul_rst_n) begin
      mul_ready_n <= 1'b1;
      mul_lat     <= $urandom_range(0, 5);
    end else if (!mul_hang) begin
      if (mul_lat == 0) begin
        mul_ready_n <= 1'b0;
        mul_result  <= 64'(mul_a) * 64'(mul_b);
      end else mul_lat <= mul_lat - 1;
    end
  end

  always @(posedge clk) begin
    if (!div_rst_n) begin
      div_ready_n <= 1'b1;
      div_lat     <= $urandom_range(0, 5);
    end else if (div_lat == 0) begin
      div_ready_n <= 1'b0;
      div_r       <= (div_b == 0) ? 64'd0 : div_a % div_b;
    end else div_lat <= div_lat - 1;
  end

  logic           p_mul_rst_n = 1'b0, p_div_rst_n = 1'b0;
  logic [W-1:0]   p_mul_a = '0, p_mul_b = '0;
  logic [2*W-1:0] p_div_a = '0, p_div_b = '0;
  always @(negedge clk) begin
    if (mul_rst_n && div_rst_n) prot_err++;
    if (mul_rst_n && p_mul_rst_n && (mul_a !== p_mul_a || mul_b !== p_mul_b)) prot_err++;
    if (div_rst_n && p_div_rst_n && (div_a !== p_div_a || div_b !== p_div_b)) prot_err++;
    p_mul_rst_n = mul_rst_n; p_div_rst_n = div_rst_n;
    p_mul_a = mul_a; p_mul_b = mul_b; p_div_a = div_a; p_div_b = div_b;
  end

  // Left-to-right exponentiation, independent of the DUT's bit order.
  function automatic logic [W-1:0] ref_modpow(input logic [W-1:0] b, e, n);
    longint unsigned r, bb;
    if (n <= 1) return '0;
    r  = 1;
    bb = 64'(b) % 64'(n);
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % 64'(n);
      if (e[i]) r = (r * bb) % 64'(n);
    end
    return r[W-1:0];
  endfunction

  task automatic pulse_start(input logic [W-1:0] b, e, n);
    @(negedge clk);
    start = 1'b1; base = b; exp = e; modulus = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output logic tmo);
    tmo = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (!ready_n) begin tmo = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [W-1:0] b, e, n,
                        output logic [W-1:0] res, output logic er, output logic tmo);
    pulse_start(b, e, n);
    wait_done(tmo);
    res = result;
    er  = err;
  endtask

  task automatic check_reset_vals(input string name);
    logic [256:0] act;
    act = {result, ready_n, busy, err, mul_rst_n, div_rst_n, mul_a, mul_b, div_a, div_b};
    vectors++;
    if (act !== {32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 64'd0, 64'd0}) begin
      miscompares++;
      $display("FAIL %s: outputs=%h, required reset values", name, act);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known;
    logic [W-1:0] res; logic er, tmo; int m0, d0;
    m0 = mul_iss; d0 = div_iss;
    run_op(32'd4, 32'd13, 32'd497, res, er, tmo);
    vectors++;
    if ({tmo, er, res} !== {1'b0, 1'b0, 32'd445}) begin
      miscompares++; $display("FAIL known_4_13_497: tmo=%0b err=%0b result=%0d, required 0 0 445", tmo, er, res);
    end
    vectors++;
    if (mul_iss - m0 !== 6 || div_iss - d0 !== 7) begin
      miscompares++; $display("FAIL op_count: mul=%0d div=%0d, required 6 7", mul_iss - m0, div_iss - d0);
    end
    run_op(32'd2, 32'd10, 32'd1000, res, er, tmo);
    vectors++;
    if ({tmo, er, res} !== {1'b0, 1'b0, 32'd24}) begin
      miscompares++; $display("FAIL known_2_10_1000: tmo=%0b err=%0b result=%0d, required 0 0 24", tmo, er, res);
    end
    run_op(32'h12345678, 32'd0, 32'd7, res, er, tmo);
    vectors++;
    if ({tmo, er, res} !== {1'b0, 1'b0, 32'd1}) begin
      miscompares++; $display("FAIL exp_zero: tmo=%0b err=%0b result=%0d, required 0 0 1", tmo, er, res);
    end
  endtask

  task automatic test_small_mod;
    logic [W-1:0] res; logic er, tmo; int m0, d0;
    run_op($urandom, $urandom, 32'd1, res, er, tmo);
    vectors++;
    if ({tmo, er, res} !== {1'b0, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL mod_one: tmo=%0b err=%0b result=%0d, required 0 0 0", tmo, er, res);
    end
    m0 = mul_iss; d0 = div_iss;
    run_op($urandom, $urandom, 32'd0, res, er, tmo);
    vectors++;
    if ({tmo, er, res} !== {1'b0, 1'b1, 32'd0}) begin
      miscompares++; $display("FAIL mod_zero: tmo=%0b err=%0b result=%0d, required 0 1 0", tmo, er, res);
    end
    vectors++;
    if (mul_iss != m0 || div_iss != d0) begin
      miscompares++; $display("FAIL mod_zero_issues: mul=%0d div=%0d, required 0 0", mul_iss - m0, div_iss - d0);
    end
  endtask

  task automatic test_timeout;
    logic tmo; int t0, dt;
    mul_hang = 1'b1;
    pulse_start(32'd3, 32'd5, 32'd11);
    t0 = -1;
    for (int i = 0; i < 500 && t0 < 0; i++) begin
      if (mul_rst_n) t0 = cyc;
      else @(negedge clk);
    end
    wait_done(tmo);
    dt = cyc - t0;
    vectors++;
    if ({tmo, ready_n, busy, err, result} !== {1'b0, 1'b0, 1'b0, 1'b1, 32'd0} || t0 < 0) begin
      miscompares++;
      $display("FAIL timeout_flags: tmo=%0b ready_n=%0b busy=%0b err=%0b result=%0d, required 0 0 0 1 0",
               tmo, ready_n, busy, err, result);
    end
    vectors++;
    if (dt != TO) begin
      miscompares++; $display("FAIL timeout_cycles: %0d, required %0d", dt, TO);
    end
    vectors++;
    if ({mul_rst_n, div_rst_n} !== 2'b00) begin
      miscompares++; $display("FAIL timeout_units: rst_n=%b, required 00", {mul_rst_n, div_rst_n});
    end
    mul_hang = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    logic tmo;
    pulse_start(32'd4, 32'd13, 32'd497);
    repeat (3) @(negedge clk);
    start = 1'b1; base = 32'd2; exp = 32'd10; modulus = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({busy, ready_n} !== 2'b11) begin
      miscompares++; $display("FAIL busy_during_op: busy=%0b ready_n=%0b, required 1 1", busy, ready_n);
    end
    wait_done(tmo);
    vectors++;
    if ({tmo, err, result} !== {1'b0, 1'b0, 32'd445}) begin
      miscompares++; $display("FAIL start_while_busy: tmo=%0b err=%0b result=%0d, required 0 0 445", tmo, err, result);
    end
  endtask

  task automatic test_async_reset;
    bit seen;
    seen = 1'b0;
    pulse_start(32'd5, 32'd2, 32'd1000);
    for (int i = 0; i < 200 && !seen; i++) begin
      if (mul_rst_n) seen = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL mulb_reached: mul_rst_n=%0b, required 1", mul_rst_n);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset_mid_mulb");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] b, e, n, res, expv; logic er, tmo;
    for (int k = 0; k < 20; k++) begin
      b = $urandom; e = $urandom; n = $urandom | 32'd1;
      if (n == 32'd1) n = 32'd3;
      expv = ref_modpow(b, e, n);
      run_op(b, e, n, res, er, tmo);
      vectors++;
      if ({tmo, er, res} !== {1'b0, 1'b0, expv}) begin
        miscompares++;
        $display("FAIL random_%0d b=%h e=%h n=%h: tmo=%0b err=%0b result=%h, required 0 0 %h",
                 k, b, e, n, tmo, er, res, expv);
      end
    end
    vectors++;
    if (prot_err != 0) begin
      miscompares++; $display("FAIL protocol: %0d violations, required 0", prot_err);
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_small_mod();
    test_timeout();
    test_busy_ignore();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
